// File: rtl/mem_4x8b_rtl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_4x8b_rtl: four-word single-port memory, valid/ready request/response  |
// | Optional: MEM_WRITE_READBACK_EN echoes write data in write responses.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mem_4x8b_rtl #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic             req_type,
  input  logic [1:0]       req_addr,
  input  logic [nbits-1:0] req_wdata,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic             resp_type,
  output logic [nbits-1:0] resp_rdata
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [nbits-1:0]       word_q [4];
  logic [3:0]             we_onehot_d;
  logic                   fire_d;
  logic                   resp_type_q;
  logic [nbits-1:0]       resp_rdata_q;
  logic [nbits-1:0]       resp_rdata_d;

  assign resp_val   = (state_q == ST_FULL);
  assign resp_type  = resp_type_q;
  assign resp_rdata = resp_rdata_q;

  // A request may enter in the same cycle the held response drains.
  assign req_rdy = !rst && (!resp_val || resp_rdy);
  assign fire_d  = req_val && req_rdy;

  always_comb begin
    we_onehot_d           = 4'b0000;
    we_onehot_d[req_addr] = 1'b1;
  end

  always_comb begin
    resp_rdata_d = word_q[req_addr];
    if (req_type) begin
`ifdef MEM_WRITE_READBACK_EN
      resp_rdata_d = req_wdata;
`else
      resp_rdata_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        word_q[i] <= '0;
      end else if (fire_d && req_type && we_onehot_d[i]) begin
        word_q[i] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      resp_type_q  <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_d) begin
            state_q      <= ST_FULL;
            resp_type_q  <= req_type;
            resp_rdata_q <= resp_rdata_d;
          end
        end
        ST_FULL: begin
          // Without resp_rdy the outputs stay bit-stable.
          if (resp_rdy) begin
            if (fire_d) begin
              resp_type_q  <= req_type;
              resp_rdata_q <= resp_rdata_d;
            end else begin
              state_q <= ST_EMPTY;
            end
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_4x8b_rtl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_4x8b_rtl: vector table, random model compare, 32-bit variant.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mem_4x8b_rtl;

  logic       clk = 1'b0;
  logic       rst, req_val, req_type, resp_rdy;
  logic       req_rdy, resp_val, resp_type;
  logic [1:0] req_addr;
  logic [7:0] req_wdata, resp_rdata;

  logic        x_rst, x_req_val, x_req_type, x_resp_rdy;
  logic        x_req_rdy, x_resp_val, x_resp_type;
  logic [1:0]  x_req_addr;
  logic [31:0] x_req_wdata, x_resp_rdata;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mem_4x8b_rtl #(.nbits(8)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
    .resp_rdata(resp_rdata)
  );

  mem_4x8b_rtl #(.nbits(32)) dut32 (
    .clk(clk), .rst(x_rst), .req_val(x_req_val), .req_rdy(x_req_rdy),
    .req_type(x_req_type), .req_addr(x_req_addr), .req_wdata(x_req_wdata),
    .resp_val(x_resp_val), .resp_rdy(x_resp_rdy), .resp_type(x_resp_type),
    .resp_rdata(x_resp_rdata)
  );

  typedef struct {
    logic       rst, val, typ;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       rrdy;
    logic       e_rdy, e_val, e_typ;
    logic [7:0] e_rd;
  } vec_t;

  function automatic logic [31:0] wexp(input logic [31:0] d);
`ifdef MEM_WRITE_READBACK_EN
    return d;
`else
    return 32'h0 & d;
`endif
  endfunction

  function automatic vec_t mk(input logic r, input logic vl, input logic t,
                              input logic [1:0] a, input logic [7:0] wd,
                              input logic rr, input logic er, input logic ev,
                              input logic et, input logic [7:0] erd);
    vec_t v;
    v.rst = r; v.val = vl; v.typ = t; v.addr = a; v.wd = wd; v.rrdy = rr;
    v.e_rdy = er; v.e_val = ev; v.e_typ = et; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  vec_t tbl[31];

  logic [7:0] m_mem [4];
  logic       m_val, m_typ;
  logic [7:0] m_rd;

  initial begin
    // Reset then reads
    tbl[0]  = mk(1,0,0,0,8'h00,1, 0,0,0,8'h00);
    tbl[1]  = mk(0,1,0,0,8'h00,1, 1,1,0,8'h00);
    tbl[2]  = mk(0,1,0,1,8'h00,1, 1,1,0,8'h00);
    tbl[3]  = mk(0,1,0,2,8'h00,1, 1,1,0,8'h00);
    tbl[4]  = mk(0,1,0,3,8'h00,1, 1,1,0,8'h00);
    // Write all words, read back reversed
    tbl[5]  = mk(0,1,1,0,8'h11,1, 1,1,1,wexp(8'h11));
    tbl[6]  = mk(0,1,1,1,8'h22,1, 1,1,1,wexp(8'h22));
    tbl[7]  = mk(0,1,1,2,8'h33,1, 1,1,1,wexp(8'h33));
    tbl[8]  = mk(0,1,1,3,8'h44,1, 1,1,1,wexp(8'h44));
    tbl[9]  = mk(0,1,0,3,8'h00,1, 1,1,0,8'h44);
    tbl[10] = mk(0,1,0,2,8'h00,1, 1,1,0,8'h33);
    tbl[11] = mk(0,1,0,1,8'h00,1, 1,1,0,8'h22);
    tbl[12] = mk(0,1,0,0,8'h00,1, 1,1,0,8'h11);
    // Read-after-write and write-after-read on address 2
    tbl[13] = mk(0,1,1,2,8'hA5,1, 1,1,1,wexp(8'hA5));
    tbl[14] = mk(0,1,0,2,8'h00,1, 1,1,0,8'hA5);
    tbl[15] = mk(0,1,0,2,8'h00,1, 1,1,0,8'hA5);
    tbl[16] = mk(0,1,1,2,8'h5A,1, 1,1,1,wexp(8'h5A));
    tbl[17] = mk(0,0,0,0,8'h00,1, 1,0,0,8'h00);
    // Backpressure on a read of address 1
    tbl[18] = mk(0,1,0,1,8'h00,0, 1,1,0,8'h22);
    tbl[19] = mk(0,1,0,3,8'h00,0, 0,1,0,8'h22);
    tbl[20] = mk(0,1,0,3,8'h00,0, 0,1,0,8'h22);
    tbl[21] = mk(0,1,0,3,8'h00,0, 0,1,0,8'h22);
    tbl[22] = mk(0,1,0,3,8'h00,1, 1,1,0,8'h44);
    tbl[23] = mk(0,0,0,0,8'h00,1, 1,0,0,8'h00);
    // Reset with a pending response
    tbl[24] = mk(0,1,0,0,8'h00,0, 1,1,0,8'h11);
    tbl[25] = mk(1,0,0,0,8'h00,0, 0,0,0,8'h00);
    tbl[26] = mk(0,1,0,0,8'h00,1, 1,1,0,8'h00);
    tbl[27] = mk(0,1,0,1,8'h00,1, 1,1,0,8'h00);
    tbl[28] = mk(0,1,0,2,8'h00,1, 1,1,0,8'h00);
    tbl[29] = mk(0,1,0,3,8'h00,1, 1,1,0,8'h00);
    tbl[30] = mk(0,0,0,0,8'h00,1, 1,0,0,8'h00);

    x_rst = 1'b1; x_req_val = 1'b0; x_req_type = 1'b0; x_req_addr = 2'd0;
    x_req_wdata = 32'h0; x_resp_rdy = 1'b1;

    for (int i = 0; i < 31; i++) begin
      rst = tbl[i].rst; req_val = tbl[i].val; req_type = tbl[i].typ;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wd; resp_rdy = tbl[i].rrdy;
      #1;
      chk($sformatf("vec%0d req_rdy", i), {31'b0, req_rdy}, {31'b0, tbl[i].e_rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d resp_val", i), {31'b0, resp_val}, {31'b0, tbl[i].e_val});
      if (tbl[i].e_val || tbl[i].rst) begin
        chk($sformatf("vec%0d resp_type", i), {31'b0, resp_type}, {31'b0, tbl[i].e_typ});
        chk($sformatf("vec%0d resp_rdata", i), {24'b0, resp_rdata}, {24'b0, tbl[i].e_rd});
      end
    end

    // Randomized traffic against a behavioural model
    begin
      logic hold, fire, e_rdy;
      hold = 1'b0;
      m_val = 1'b0; m_typ = 1'b0; m_rd = 8'h00;
      for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
      for (int c = 0; c < 600; c++) begin
        if (!hold) begin
          req_val   = ($urandom % 4) != 0;
          req_type  = 1'($urandom % 2);
          req_addr  = 2'($urandom % 4);
          req_wdata = 8'($urandom);
        end
        resp_rdy = ($urandom % 3) != 0;
        rst      = (c == 0) || (($urandom % 64) == 0);
        #1;
        e_rdy = !rst && (!m_val || resp_rdy);
        chk("rand req_rdy", {31'b0, req_rdy}, {31'b0, e_rdy});
        fire = req_val && e_rdy;
        hold = req_val && !fire && !rst;
        @(posedge clk); #1;
        if (rst) begin
          for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
          m_val = 1'b0; m_typ = 1'b0; m_rd = 8'h00;
        end else if (fire) begin
          m_val = 1'b1;
          m_typ = req_type;
          m_rd  = req_type ? 8'(wexp({24'b0, req_wdata})) : m_mem[req_addr];
          if (req_type) m_mem[req_addr] = req_wdata;
        end else if (resp_rdy) begin
          m_val = 1'b0;
        end
        chk("rand resp_val", {31'b0, resp_val}, {31'b0, m_val});
        if (m_val) begin
          chk("rand resp_type", {31'b0, resp_type}, {31'b0, m_typ});
          chk("rand resp_rdata", {24'b0, resp_rdata}, {24'b0, m_rd});
        end
      end
      rst = 1'b0; req_val = 1'b0;
    end

    // 32-bit variant: write address 3, then read all four words
    @(posedge clk); #1;
    x_rst = 1'b0; x_req_val = 1'b1; x_req_type = 1'b1; x_req_addr = 2'd3;
    x_req_wdata = 32'hDEADBEEF;
    #1;
    chk("w32 req_rdy", {31'b0, x_req_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("w32 write resp_val", {31'b0, x_resp_val}, 32'd1);
    chk("w32 write resp_type", {31'b0, x_resp_type}, 32'd1);
    chk("w32 write resp_rdata", x_resp_rdata, wexp(32'hDEADBEEF));
    for (int a = 3; a >= 0; a--) begin
      x_req_type = 1'b0; x_req_addr = 2'(a); x_req_wdata = 32'h0;
      @(posedge clk); #1;
      chk($sformatf("w32 read%0d resp_val", a), {31'b0, x_resp_val}, 32'd1);
      chk($sformatf("w32 read%0d resp_rdata", a), x_resp_rdata,
          (a == 3) ? 32'hDEADBEEF : 32'h0);
    end
    x_req_val = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
